// File: rtl/wide_add_pkg.sv
// -----------------------------------------------------------------------------
// wide_add_pkg
// Shared definitions for the time-shared wide adder (wide_add_seq):
//   - state_e : controller state encoding (2 bits)
//   - SLICE_W : width of the ripple-carry slice reused every cycle
//   - signed_ovf() : two's-complement overflow rule from the sign bits
// -----------------------------------------------------------------------------
package wide_add_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Signed overflow: both addends share a sign and the result sign differs.
    function automatic logic signed_ovf(input logic a_msb,
                                        input logic b_msb,
                                        input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/wide_add_seq_rca_4b.sv
// -----------------------------------------------------------------------------
// rca_4b
// Combinational 4-bit ripple-carry adder slice.
// Ports:
//   a, b : SLICE_W-bit addends
//   ci   : carry in
//   s    : SLICE_W-bit sum
//   co   : carry out of the top bit
// -----------------------------------------------------------------------------
module rca_4b
    import wide_add_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               co
);

    logic [SLICE_W:0] carry_s;

    // Bit-serial ripple: each full adder feeds its carry to the next bit.
    always_comb begin
        carry_s    = '0;
        s          = '0;
        carry_s[0] = ci;
        for (int i = 0; i < SLICE_W; i++) begin
            s[i]         = a[i] ^ b[i] ^ carry_s[i];
            carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
        end
        co = carry_s[SLICE_W];
    end

endmodule

// File: rtl/wide_add_seq.sv
// -----------------------------------------------------------------------------
// wide_add_seq
// Multi-cycle W-bit adder that reuses one 4-bit ripple-carry slice over
// N = W/4 cycles, least-significant nibble first, chaining the carry through
// a register. Latency is N+1 cycles after accept; done pulses for one cycle.
//
// Parameters:
//   W     : operand/result width, multiple of 4 and >= 4 (default 16)
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous reset, active-high (wins over start)
//   start : request, sampled only while idle
//   a, b  : W-bit operands, captured on accept
//   cin   : carry in, captured on accept
//   sub   : subtract request, captured on accept (see macro below)
//   busy  : high while running or in the done cycle
//   done  : one-cycle completion pulse
//   sum   : W-bit result register
//   cout  : carry out of bit W-1 (1 = no borrow when subtracting)
//   ovf   : signed overflow
//
// Configuration macro WIDE_ADD_SEQ_SUB_EN:
//   defined     : sub=1 computes a - b (loads ~b, carry forced to 1, cin ignored)
//   not defined : sub is ignored; always computes a + b + cin
// -----------------------------------------------------------------------------
module wide_add_seq
    import wide_add_pkg::*;
#(
    parameter int W = 16
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int N     = W / SLICE_W;
    // A single-slice build still needs a one-bit counter.
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

    generate
        if ((W < SLICE_W) || ((W % SLICE_W) != 0)) begin : g_bad_width
            $error("wide_add_seq: W must be a multiple of 4 and at least 4");
        end
    endgenerate

    state_e             state_r;
    state_e             state_next_s;
    logic               accept_s;
    logic               step_s;
    logic               last_s;

    logic [W-1:0]       op_a_r;
    logic [W-1:0]       op_b_r;
    logic               carry_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [W-1:0]       sum_r;
    logic               cout_r;
    logic               ovf_r;
    logic               busy_r;
    logic               done_r;

    logic [W-1:0]       b_load_s;
    logic               c_load_s;
    logic [SLICE_W-1:0] slice_sum_s;
    logic               slice_co_s;
    logic [W-1:0]       sum_shift_s;

`ifdef WIDE_ADD_SEQ_SUB_EN
    // Operand B / initial carry selection: subtract is a + ~b + 1.
    always_comb begin
        b_load_s = b;
        c_load_s = cin;
        if (sub) begin
            b_load_s = ~b;
            c_load_s = 1'b1;
        end else begin
            b_load_s = b;
            c_load_s = cin;
        end
    end
`else
    logic unused_sub_s;
    assign unused_sub_s = sub;

    // Operand B / initial carry selection: add only, sub has no effect.
    always_comb begin
        b_load_s = b;
        c_load_s = cin;
    end
`endif

    rca_4b u_slice (
        .a  (op_a_r[SLICE_W-1:0]),
        .b  (op_b_r[SLICE_W-1:0]),
        .ci (carry_r),
        .s  (slice_sum_s),
        .co (slice_co_s)
    );

    // New nibble enters at the MSB end so after N cycles it sits LSB-aligned.
    generate
        if (W == SLICE_W) begin : g_one_slice
            assign sum_shift_s = slice_sum_s;
        end else begin : g_multi_slice
            assign sum_shift_s = {slice_sum_s, sum_r[W-1:SLICE_W]};
        end
    endgenerate

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode and per-cycle datapath controls.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        step_s       = 1'b0;
        last_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                step_s = 1'b1;
                if (cnt_r == LAST_IDX) begin
                    last_s       = 1'b1;
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Operand capture, per-slice shifting, carry chaining and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a_r  <= '0;
            op_b_r  <= '0;
            carry_r <= 1'b0;
            cnt_r   <= '0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (accept_s) begin
            op_a_r  <= a;
            op_b_r  <= b_load_s;
            carry_r <= c_load_s;
            cnt_r   <= '0;
        end else if (step_s) begin
            op_a_r  <= op_a_r >> SLICE_W;
            op_b_r  <= op_b_r >> SLICE_W;
            carry_r <= slice_co_s;
            cnt_r   <= cnt_r + CNT_W'(1);
            sum_r   <= sum_shift_s;
            // On the last slice the operand registers hold the top nibbles,
            // so their bit 3 is the sign of A and of the effective B.
            if (last_s) begin
                cout_r <= slice_co_s;
                ovf_r  <= signed_ovf(op_a_r[SLICE_W-1], op_b_r[SLICE_W-1],
                                     slice_sum_s[SLICE_W-1]);
            end
        end
    end

    // Status flags registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s != ST_IDLE);
            done_r <= (state_next_s == ST_DONE);
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_wide_add_seq.sv
// -----------------------------------------------------------------------------
// tb_wide_add_seq
// Self-checking bench for wide_add_seq (W=16). A behavioural model tracks
// accepts and the cycle count since accept, computing results with plain
// W+1-bit arithmetic; a negedge compare process checks busy/done every cycle
// and sum/cout/ovf whenever they are defined. Directed cases add literal
// expectations, followed by randomized traffic with random resets.
// -----------------------------------------------------------------------------
module tb_wide_add_seq;

    localparam int W = 16;
    localparam int N = W / 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    wide_add_seq #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sub   (sub),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: returns {ovf, cout, sum}.
    function automatic logic [W+1:0] calc(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                          input logic fc, input logic fs);
        logic [W-1:0] be;
        logic         c;
        logic [W:0]   full;
        logic [W-1:0] s;
`ifndef WIDE_ADD_SEQ_SUB_EN
        logic         unused_fs;
        unused_fs = fs;
`endif
        be = fb;
        c  = fc;
`ifdef WIDE_ADD_SEQ_SUB_EN
        if (fs) begin
            be = ~fb;
            c  = 1'b1;
        end
`endif
        full = {1'b0, fa} + {1'b0, be} + {{W{1'b0}}, c};
        s    = full[W-1:0];
        return {((fa[W-1] == be[W-1]) && (s[W-1] != fa[W-1])), full[W], s};
    endfunction

    // Behavioural model: age counts cycles since accept (1..N run, N+1 done).
    logic         m_init = 1'b0;
    logic         m_active = 1'b0;
    logic         m_valid = 1'b0;
    int           m_age = 0;
    logic [W-1:0] m_sum = '0;
    logic         m_cout = 1'b0;
    logic         m_ovf = 1'b0;
    logic [W+1:0] m_pend = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_init   <= 1'b1;
            m_active <= 1'b0;
            m_age    <= 0;
            m_valid  <= 1'b1;
            m_sum    <= '0;
            m_cout   <= 1'b0;
            m_ovf    <= 1'b0;
        end else if (!m_active) begin
            if (start) begin
                m_active <= 1'b1;
                m_age    <= 1;
                m_valid  <= 1'b0;
                m_pend   <= calc(a, b, cin, sub);
            end
        end else if (m_age == N + 1) begin
            m_active <= 1'b0;
            m_age    <= 0;
        end else begin
            m_age <= m_age + 1;
            if (m_age == N) begin
                m_valid <= 1'b1;
                {m_ovf, m_cout, m_sum} <= m_pend;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_init) begin
            chk("busy", 32'(busy), 32'(m_active));
            chk("done", 32'(done), 32'(m_active && (m_age == N + 1)));
            if (m_valid) begin
                chk("sum", 32'(sum), 32'(m_sum));
                chk("cout", 32'(cout), 32'(m_cout));
                chk("ovf", 32'(ovf), 32'(m_ovf));
            end
        end
    end

    // Issue one request from idle; lat = cycles from accept to done (-1 on timeout).
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_op,
                         input logic tc, input logic ts, output int lat);
        bit found;
        @(posedge clk); #1;
        a = ta; b = tb_op; cin = tc; sub = ts; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = -1;
        found = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (!found) begin
                @(negedge clk);
                if (done) begin
                    lat   = i;
                    found = 1'b1;
                end
            end
        end
    endtask

    task automatic op_expect(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_op,
                             input logic tc, input logic ts, input logic [W-1:0] es,
                             input logic ec, input logic eo);
        int lat;
        do_op(ta, tb_op, tc, ts, lat);
        chk({name, "_lat"}, 32'(lat), 32'd5);
        chk({name, "_sum"}, 32'(sum), 32'(es));
        chk({name, "_cout"}, 32'(cout), 32'(ec));
        chk({name, "_ovf"}, 32'(ovf), 32'(eo));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dq[$];
        bit saw_done;

        // Pin the reference arithmetic itself.
        chk("model_add", 32'(calc(16'h1234, 16'h0FFF, 1'b0, 1'b0)), {14'd0, 2'b00, 16'h2233});
        chk("model_ovf", 32'(calc(16'h8000, 16'hFFFF, 1'b0, 1'b0)), {14'd0, 2'b11, 16'h7FFF});

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_sum", 32'(sum), 32'd0);
        chk("reset_cout", 32'(cout), 32'd0);
        chk("reset_ovf", 32'(ovf), 32'd0);

        op_expect("add1", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);
        op_expect("carry", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        op_expect("povf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        op_expect("novf", 16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        op_expect("cin", 16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
`ifdef WIDE_ADD_SEQ_SUB_EN
        op_expect("sub1", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
        op_expect("sub2", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
`else
        op_expect("sub1", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h000C, 1'b0, 1'b0);
        op_expect("sub2", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'h000C, 1'b0, 1'b0);
`endif

        // Abort: start pulsed in RUN, reset in the second RUN cycle.
        @(posedge clk); #1;
        a = 16'h00AA; b = 16'h0055; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        chk("abort_ovf", 32'(ovf), 32'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("abort_no_done", 32'(saw_done), 32'd0);

        // Reset and start together: request dropped.
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_start_busy", 32'(busy), 32'd0);

        op_expect("after_abort", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

        // Back-to-back: start held for 20 cycles with changing operands.
        @(posedge clk); #1;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) dq.push_back(cyc);
            @(posedge clk); #1;
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        end
        start = 1'b0;
        chk("b2b_count", 32'(dq.size()), 32'd3);
        for (int i = 1; i < dq.size(); i++) begin
            chk("b2b_period", 32'(dq[i] - dq[i-1]), 32'd6);
        end
        repeat (10) @(posedge clk);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            case ($urandom_range(0, 4))
                0: a = 16'hFFFF;
                1: a = 16'h8000;
                2: a = 16'h7FFF;
                default: a = 16'($urandom);
            endcase
            case ($urandom_range(0, 4))
                0: b = 16'hFFFF;
                1: b = 16'h0001;
                2: b = 16'h8000;
                default: b = 16'($urandom);
            endcase
            cin   = 1'($urandom);
            sub   = 1'($urandom);
            start = ($urandom_range(0, 3) != 0);
            rst   = ($urandom_range(0, 39) == 0);
        end
        #1 rst = 1'b0; start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
